// File: rtl/sl_preceptron_mem_reader.sv
// sl_preceptron_mem_reader: streams `length` consecutive RAM words from `base_addr` as valid/ready beats.
// Optional running checksum output enabled by defining SL_PRECEPTRON_RD_CHECKSUM_EN.
`default_nettype none

module sl_preceptron_mem_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [ADDR_WIDTH:0]     length,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_wen,
    output logic                    mem_ren,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
`ifdef SL_PRECEPTRON_RD_CHECKSUM_EN
    output logic [DATA_WIDTH+7:0]   checksum,
`endif
    output logic                    out_last
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH:0]     len_q;
    logic [ADDR_WIDTH:0]     issued_q;
    logic [ADDR_WIDTH:0]     popped_q;
    logic                    inflight_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   fifo_q [2];
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [1:0]              cnt_q;
    // Zero-length commands spend one extra cycle in FIN so done lands two cycles after accept.
    logic                    zwait_q;
`ifdef SL_PRECEPTRON_RD_CHECKSUM_EN
    logic [DATA_WIDTH+7:0]   checksum_q;
`endif

    logic                    w_accept;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_ren;
    logic [2:0]              w_occ;
    logic [ADDR_WIDTH-1:0]   w_rd_addr;

    assign w_accept  = (state_q == S_IDLE) && start;
    assign out_valid = (cnt_q != 2'd0);
    assign w_pop     = out_valid && out_ready;
    assign w_push    = inflight_q;
    // Credit: words buffered plus the word in flight, less the one leaving now, must stay below 2.
    assign w_occ     = {1'b0, cnt_q} + {2'b00, inflight_q};
    assign w_rd_addr = base_q + issued_q[ADDR_WIDTH-1:0];
    assign w_ren     = (state_q == S_READ) && (issued_q < len_q)
                       && (w_occ < (3'd2 + {2'b00, w_pop}));

    assign mem_wen   = 1'b0;
    assign mem_wdata = '0;
    assign mem_ren   = w_ren;
    assign mem_addr  = w_ren ? w_rd_addr : addr_q;
    assign out_data  = fifo_q[rd_ptr_q];
    assign out_last  = out_valid && (popped_q == (len_q - 1'b1));
    assign busy      = (state_q == S_READ) || (state_q == S_DRAIN);
    assign done      = (state_q == S_FIN) && !zwait_q;
`ifdef SL_PRECEPTRON_RD_CHECKSUM_EN
    assign checksum  = checksum_q;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (length == '0) ? S_FIN : S_READ;
                end
            end
            S_READ: begin
                if (w_ren && ((issued_q + 1'b1) == len_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && out_last) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                if (!zwait_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            inflight_q <= 1'b0;
            addr_q     <= '0;
            zwait_q    <= 1'b0;
        end else begin
            inflight_q <= w_ren;
            if (w_accept) begin
                base_q   <= base_addr;
                len_q    <= length;
                issued_q <= '0;
                popped_q <= '0;
                zwait_q  <= (length == '0);
            end else begin
                if (state_q == S_FIN) begin
                    zwait_q <= 1'b0;
                end
                if (w_ren) begin
                    issued_q <= issued_q + 1'b1;
                    addr_q   <= w_rd_addr;
                end
                if (w_pop) begin
                    popped_q <= popped_q + 1'b1;
                end
            end
        end
    end

    // Two-entry output FIFO; the credit rule keeps cnt_q at or below 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            if (w_push) begin
                fifo_q[wr_ptr_q] <= mem_rdata;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({w_push, w_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

`ifdef SL_PRECEPTRON_RD_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else if (w_accept) begin
            checksum_q <= '0;
        end else if (w_pop) begin
            checksum_q <= checksum_q + {8'd0, out_data};
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sl_preceptron_mem_reader.sv
// Self-checking bench for sl_preceptron_mem_reader: RAM model plus queue-based stream reference.
`timescale 1ns/1ps
`default_nettype none

module tb_sl_preceptron_mem_reader;
    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy, done, mem_wen, mem_ren, out_valid, out_ready, out_last;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, out_data;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] ram [DEPTH];
    int            total = 0;
    int            bad   = 0;
`ifdef SL_PRECEPTRON_RD_CHECKSUM_EN
    logic [DW+7:0] checksum;
`endif

    sl_preceptron_mem_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef SL_PRECEPTRON_RD_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= ram[mem_addr];
    end

    // Packs every output so a reset can be checked in one comparison.
    function automatic logic [63:0] all_outputs();
        logic [63:0] v;
        v = {34'd0, busy, done, mem_wen, mem_ren, mem_addr, mem_wdata, out_valid, out_data, out_last};
`ifdef SL_PRECEPTRON_RD_CHECKSUM_EN
        v = v | ({48'd0, checksum} << 30);
`endif
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (all_outputs() !== 64'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0", all_outputs());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // mode 0: ready always 1; mode 1: ready pattern 1,0,0,1; mode 2: random ready.
    // inj_c > 0 pulses a foreign start (base 0, length 3) on that cycle of the command.
    task automatic run_cmd(input int b, input int n, input int mode, input int inj_c, input string nm);
        logic [DW-1:0] exp_q [$];
        logic [DW+7:0] sum;
        logic [DW-1:0] hold_d;
        logic          hold_l, stall, pop, done_exp, busy_exp, finished;
        int            c, issued, got, hs_last_c;
        exp_q.delete();
        sum = '0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(ram[(b + i) % DEPTH]);
            sum = sum + {8'd0, ram[(b + i) % DEPTH]};
        end
        @(negedge clk);
        start = 1'b1; base_addr = b[AW-1:0]; length = n[AW:0]; out_ready = 1'b1;
        c = 0; issued = 0; got = 0; hs_last_c = -1; stall = 1'b0; finished = 1'b0;
        hold_d = '0; hold_l = 1'b0;
        while (!finished && c < 600) begin
            @(negedge clk);
            c++;
            start = (c == inj_c);
            if (c == inj_c) begin
                base_addr = '0;
                length    = 7'd3;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((c % 4) == 1) || ((c % 4) == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            pop = out_valid && out_ready;
            total++;
            if (mem_wen !== 1'b0 || mem_wdata !== '0) begin
                bad++;
                $display("FAIL %s wen_tie c=%0d: wen=%b wdata=%h expected 0", nm, c, mem_wen, mem_wdata);
            end
            if (mode == 0) begin
                total++;
                if (mem_ren !== (c <= n) || out_valid !== (c >= 3 && c <= n + 2)) begin
                    bad++;
                    $display("FAIL %s timing c=%0d: ren=%b valid=%b expected ren=%b valid=%b",
                             nm, c, mem_ren, out_valid, (c <= n), (c >= 3 && c <= n + 2));
                end
            end
            if (mem_ren) begin
                total++;
                if (mem_addr !== AW'((b + issued) % DEPTH) || issued >= n
                    || (issued - got - int'(pop)) >= 2) begin
                    bad++;
                    $display("FAIL %s read c=%0d: addr=%0d issued=%0d got=%0d expected addr=%0d",
                             nm, c, mem_addr, issued, got, (b + issued) % DEPTH);
                end
                issued++;
            end
            if (stall) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== hold_d || out_last !== hold_l) begin
                    bad++;
                    $display("FAIL %s hold c=%0d: valid=%b data=%h last=%b expected 1 %h %b",
                             nm, c, out_valid, out_data, out_last, hold_d, hold_l);
                end
            end
            if (pop) begin
                total++;
                if (got >= n) begin
                    bad++;
                    $display("FAIL %s extra_word c=%0d: data=%h expected no word", nm, c, out_data);
                end else if (out_data !== exp_q[got] || out_last !== (got == n - 1)) begin
                    bad++;
                    $display("FAIL %s data[%0d] c=%0d: data=%h last=%b expected %h %b",
                             nm, got, c, out_data, out_last, exp_q[got], (got == n - 1));
                end
                if (got == n - 1) hs_last_c = c;
                got++;
            end
            done_exp = (n == 0) ? (c == 2) : (hs_last_c > 0 && c == hs_last_c + 1);
            busy_exp = (n != 0) && !(hs_last_c > 0 && c > hs_last_c);
            total++;
            if (done !== done_exp || busy !== busy_exp) begin
                bad++;
                $display("FAIL %s ctrl c=%0d: done=%b busy=%b expected %b %b",
                         nm, c, done, busy, done_exp, busy_exp);
            end
            stall    = out_valid && !out_ready;
            hold_d   = out_data;
            hold_l   = out_last;
            finished = done_exp || (done === 1'b1);
        end
        total++;
        if (!finished) begin
            bad++;
            $display("FAIL %s timeout: got=%0d words expected %0d", nm, got, n);
        end else if (got != n) begin
            bad++;
            $display("FAIL %s word_count: got=%0d expected %0d", nm, got, n);
        end
`ifdef SL_PRECEPTRON_RD_CHECKSUM_EN
        total++;
        if (checksum !== sum) begin
            bad++;
            $display("FAIL %s checksum: got=%0d expected %0d", nm, checksum, sum);
        end
`endif
        @(negedge clk);
        start = 1'b0;
        #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s after_done: done=%b busy=%b valid=%b expected 0 0 0", nm, done, busy, out_valid);
        end
    endtask

    task automatic test_reset_abort();
        int got;
        int c;
        @(negedge clk);
        start = 1'b1; base_addr = 6'd10; length = 7'd8; out_ready = 1'b1;
        got = 0; c = 0;
        while (got < 2 && c < 50) begin
            @(negedge clk);
            start = 1'b0;
            c++;
            #1;
            if (out_valid && out_ready) got++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (all_outputs() !== 64'd0) begin
            bad++;
            $display("FAIL abort_outputs: got %h expected 0", all_outputs());
        end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            total++;
            if (done !== 1'b0 || out_valid !== 1'b0 || mem_ren !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL abort_quiet i=%0d: done=%b valid=%b ren=%b busy=%b expected 0",
                         i, done, out_valid, mem_ren, busy);
            end
        end
        run_cmd(20, 5, 0, 0, "after_abort");
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i + 1);
        test_reset();
        run_cmd(4, 5, 0, 0, "basic");
        run_cmd(62, 4, 0, 0, "wrap");
        run_cmd(7, 6, 1, 0, "backpressure");
        run_cmd(9, 0, 0, 0, "zero_len");
        run_cmd(30, 6, 0, 4, "start_ignored");
        test_reset_abort();
        run_cmd(50, 64, 0, 0, "full_ram");
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
        for (int k = 0; k < 8; k++) begin
            run_cmd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)),
                    2, int'($urandom_range(0, 2)), "random");
        end
        run_cmd(63, 64, 1, 2, "full_backpressure");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
